ctrl_pipeline_unit: RTL and testbench
=====================================

Name: ctrl_pipeline_unit

Overview:
Registered, parametrised decode-and-control stage for the MIPS pipeline, sitting between IF/ID and ID/EX.
- Decodes the instruction class flags and funct into the full control bundle, then registers it as the ID/EX control word.
- Inserts bubbles on hazard or flush.
- Sequences HALT through a drain state machine.
- Flags illegal encodings.
- Every output field is defined for every input; no latched decode.

Parameters:
ALU_OP_W, 4, ALU opcode width (ALU opcode encodings live in the shared package)
AGU_OP_W, 3, AGU opcode width
DRAIN_CYCLES, 4, cycles after a HALT bubble until the pipeline is empty (>=1)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_valid  in  1  IF/ID holds a valid instruction
i_funct  in  6  R funct, or low opcode bits for I-type ALU ops
i_flg_pc_modify, i_flg_link_ret, i_flg_inmediate, i_flg_mem_op, i_flg_mem_type, i_flg_halt  in  1 each  instruction class flags
i_flg_addr_type  in  2  jump/branch address type
i_hazard_detected  in  1  load-use stall
i_flush  in  1  taken branch/jump, kill the ID instruction
o_valid  out  1  ID/EX control word is live
o_flg_ALU_src_a, o_flg_ALU_dst, o_extend_sign  out  2 each
o_flg_ALU_src_b, o_flg_AGU_src_addr, o_flg_jump, o_flg_branch, o_flg_reg_wr_en, o_flg_mem_wr_en, o_flg_wb_src, o_flg_jmp_trg_reg  out  1 each
o_ALU_opcode  out  ALU_OP_W
o_flg_AGU_opcode  out  AGU_OP_W
o_stall_fetch  out  1  hold PC and IF/ID
o_halted  out  1  pipeline drained after HALT
o_illegal  out  1  sticky illegal-encoding flag

Behaviour:
- Reset: all outputs 0, FSM=RUN, drain counter 0.
- Latency: 1 cycle. Decode is combinational; the control word is registered on i_clk.
- Decode key K = {pc_modify, link_ret, addr_type, inmediate, mem_op}:
  - 0???0?: R-type
  - 100000: JR
  - 110000: JALR
  - 000011: load/store
  - 000010: I-type ALU
  - 101010: branch
  - 1?0100: J/JAL
  - Per-class field values are fixed in the package table.
- Unlisted K, or an unmapped funct in the R-type or I-type ALU class, is illegal.
  - An illegal instruction becomes a bubble and sets o_illegal until reset.
- Bubble: o_valid=0 and all fields 0, in particular o_flg_reg_wr_en=0 and o_flg_mem_wr_en=0.
- Issue priority each cycle, evaluated in RUN:
  1. i_flush: bubble. Also cancels a HALT in ID.
  2. i_hazard_detected: bubble and o_stall_fetch=1. The instruction is re-decoded next cycle.
  3. !i_valid: bubble.
  4. i_flg_halt: bubble, enter DRAIN, counter=DRAIN_CYCLES-1.
  5. Otherwise: register the decoded word, o_valid=1.
- FSM:
  - RUN: as above.
  - DRAIN: bubbles only; o_stall_fetch=1; i_flush, i_valid and i_hazard_detected are ignored. When counter==0, go to HALTED; otherwise decrement.
  - HALTED: bubbles, o_stall_fetch=1, o_halted=1. Leaves only on i_reset.
- Timing: o_halted rises exactly DRAIN_CYCLES cycles after the cycle in which the HALT was accepted (HALT accepted in cycle N -> o_halted=1 from cycle N+DRAIN_CYCLES).
- o_stall_fetch is combinational from FSM state and i_hazard_detected (same cycle); all other outputs are registered.
- Reset mid-DRAIN: returns to RUN at once, outputs cleared, o_illegal cleared.
- Simultaneous hazard+halt: stall wins; the HALT is accepted on a later non-hazard cycle.

Decomposition:
- Shared package `ctrl_pkg`:
  - ALU opcode defines (SHIFT_LEFT 0001, SHIFT_RIGHT 0000, SHIFT_RIGHT_ARIT 0010, ADD 0100, SUB 0101, AND 0110, OR 0111, XOR 1000, NOR 1001, SLT 1010, SIGNED_ADD 1100, PASS 0011, CMP 1011)
  - R and I funct codes
  - extend modes
  - AGU opcodes
  - class key constants
  - FSM state encodings
- Sub-module `ctrl_decode`: pure combinational decode, fully defaulted, producing the control word plus an illegal bit. The top level holds the register, priority logic and FSM.

Test Plan:
- ADDU (K=000000, funct 100001) with i_valid=1 -> next cycle: o_valid=1, ALU_opcode=0100, src_a=01, dst=01, reg_wr_en=1, wb_src=1.
- LW (K=000011, mem_type=0) then SW (mem_type=1) -> LW: reg_wr_en=1, mem_wr_en=0, wb_src=0. SW: reg_wr_en=0, mem_wr_en=1.
- ADDU with i_hazard_detected=1 for 2 cycles -> o_stall_fetch=1 on those cycles, 2 bubbles (both wr_en=0), then the ADDU word.
- HALT accepted at cycle 10 with DRAIN_CYCLES=4 -> o_stall_fetch=1 from cycle 10; o_halted=1 from cycle 14; a flush during cycles 11-13 has no effect; i_reset at cycle 20 -> o_halted=0.
- HALT with i_flush=1 in the same cycle -> bubble, FSM stays RUN, o_halted never rises.
- R-type funct 111111, then K=111111 -> bubble; o_illegal=1 and stays 1 until i_reset.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared encodings for the ID-stage control decoder: ALU/AGU opcodes, funct codes,
// operand selects, class keys and the issue FSM states.
package ctrl_pkg;

    localparam logic [3:0] ALU_SHIFT_RIGHT      = 4'b0000;
    localparam logic [3:0] ALU_SHIFT_LEFT       = 4'b0001;
    localparam logic [3:0] ALU_SHIFT_RIGHT_ARIT = 4'b0010;
    localparam logic [3:0] ALU_PASS             = 4'b0011;
    localparam logic [3:0] ALU_ADD              = 4'b0100;
    localparam logic [3:0] ALU_SUB              = 4'b0101;
    localparam logic [3:0] ALU_AND              = 4'b0110;
    localparam logic [3:0] ALU_OR               = 4'b0111;
    localparam logic [3:0] ALU_XOR              = 4'b1000;
    localparam logic [3:0] ALU_NOR              = 4'b1001;
    localparam logic [3:0] ALU_SLT              = 4'b1010;
    localparam logic [3:0] ALU_CMP              = 4'b1011;
    localparam logic [3:0] ALU_SIGNED_ADD       = 4'b1100;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_SRA  = 6'b000011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_SRLV = 6'b000110;
    localparam logic [5:0] FN_SRAV = 6'b000111;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;

    localparam logic [5:0] FI_ADDI  = 6'b001000;
    localparam logic [5:0] FI_ADDIU = 6'b001001;
    localparam logic [5:0] FI_SLTI  = 6'b001010;
    localparam logic [5:0] FI_ANDI  = 6'b001100;
    localparam logic [5:0] FI_ORI   = 6'b001101;
    localparam logic [5:0] FI_XORI  = 6'b001110;
    localparam logic [5:0] FI_LUI   = 6'b001111;

    localparam logic [1:0] EXT_ZERO  = 2'b00;
    localparam logic [1:0] EXT_SIGN  = 2'b01;
    localparam logic [1:0] EXT_UPPER = 2'b10;

    localparam logic [1:0] SRC_A_NONE  = 2'b00;
    localparam logic [1:0] SRC_A_RS    = 2'b01;
    localparam logic [1:0] SRC_A_SHAMT = 2'b10;
    localparam logic [1:0] SRC_A_LINK  = 2'b11;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [2:0] AGU_NONE     = 3'b000;
    localparam logic [2:0] AGU_BASE_OFF = 3'b001;
    localparam logic [2:0] AGU_PC_REL   = 3'b010;
    localparam logic [2:0] AGU_JUMP     = 3'b011;
    localparam logic [2:0] AGU_REG      = 3'b100;

    // Key = {pc_modify, link_ret, addr_type[1:0], inmediate, mem_op}
    localparam logic [5:0] K_RTYPE  = 6'b0???0?;
    localparam logic [5:0] K_JR     = 6'b100000;
    localparam logic [5:0] K_JALR   = 6'b110000;
    localparam logic [5:0] K_LDST   = 6'b000011;
    localparam logic [5:0] K_ITYPE  = 6'b000010;
    localparam logic [5:0] K_BRANCH = 6'b101010;
    localparam logic [5:0] K_JUMP   = 6'b1?0100;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] src_a;
        logic [1:0] dst;
        logic [1:0] ext;
        logic       src_b;
        logic       agu_src;
        logic       jump;
        logic       branch;
        logic       reg_wr_en;
        logic       mem_wr_en;
        logic       wb_src;
        logic       jmp_trg_reg;
        logic [3:0] alu_op;
        logic [2:0] agu_op;
    } ctrl_word_t;

    // Returns {mapped, alu_opcode}
    function automatic logic [4:0] r_funct_alu(input logic [5:0] funct);
        logic [4:0] r;
        r = 5'b0;
        case (funct)
            FN_SLL, FN_SLLV: r = {1'b1, ALU_SHIFT_LEFT};
            FN_SRL, FN_SRLV: r = {1'b1, ALU_SHIFT_RIGHT};
            FN_SRA, FN_SRAV: r = {1'b1, ALU_SHIFT_RIGHT_ARIT};
            FN_ADD:          r = {1'b1, ALU_SIGNED_ADD};
            FN_ADDU:         r = {1'b1, ALU_ADD};
            FN_SUB, FN_SUBU: r = {1'b1, ALU_SUB};
            FN_AND:          r = {1'b1, ALU_AND};
            FN_OR:           r = {1'b1, ALU_OR};
            FN_XOR:          r = {1'b1, ALU_XOR};
            FN_NOR:          r = {1'b1, ALU_NOR};
            FN_SLT:          r = {1'b1, ALU_SLT};
            default:         r = 5'b0;
        endcase
        return r;
    endfunction

    function automatic logic [4:0] i_funct_alu(input logic [5:0] funct);
        logic [4:0] r;
        r = 5'b0;
        case (funct)
            FI_ADDI:  r = {1'b1, ALU_SIGNED_ADD};
            FI_ADDIU: r = {1'b1, ALU_ADD};
            FI_SLTI:  r = {1'b1, ALU_SLT};
            FI_ANDI:  r = {1'b1, ALU_AND};
            FI_ORI:   r = {1'b1, ALU_OR};
            FI_XORI:  r = {1'b1, ALU_XOR};
            FI_LUI:   r = {1'b1, ALU_PASS};
            default:  r = 5'b0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/ctrl_pipeline_unit_decode.sv
// Combinational class/funct decode into a control word; an illegal encoding
// yields an all-zero word with the illegal bit set.
module ctrl_decode
    import ctrl_pkg::*;
(
    input  logic [5:0] key,
    input  logic [5:0] funct,
    input  logic       mem_type,
    output ctrl_word_t word,
    output logic       illegal
);

    logic [4:0] alu_lookup;

    always_comb begin
        word       = '0;
        illegal    = 1'b0;
        alu_lookup = '0;
        casez (key)
            K_RTYPE: begin
                alu_lookup     = r_funct_alu(funct);
                illegal        = ~alu_lookup[4];
                word.alu_op    = alu_lookup[3:0];
                word.src_a     = (funct == FN_SLL || funct == FN_SRL || funct == FN_SRA)
                                 ? SRC_A_SHAMT : SRC_A_RS;
                word.dst       = DST_RD;
                word.reg_wr_en = 1'b1;
                word.wb_src    = 1'b1;
            end
            K_ITYPE: begin
                alu_lookup     = i_funct_alu(funct);
                illegal        = ~alu_lookup[4];
                word.alu_op    = alu_lookup[3:0];
                word.src_a     = SRC_A_RS;
                word.src_b     = 1'b1;
                word.dst       = DST_RT;
                word.reg_wr_en = 1'b1;
                word.wb_src    = 1'b1;
                if (funct == FI_ANDI || funct == FI_ORI || funct == FI_XORI)
                    word.ext = EXT_ZERO;
                else if (funct == FI_LUI)
                    word.ext = EXT_UPPER;
                else
                    word.ext = EXT_SIGN;
            end
            K_LDST: begin
                word.src_a  = SRC_A_RS;
                word.ext    = EXT_SIGN;
                word.agu_op = AGU_BASE_OFF;
                if (mem_type) begin
                    word.mem_wr_en = 1'b1;
                end else begin
                    word.reg_wr_en = 1'b1;
                    word.dst       = DST_RT;
                end
            end
            K_JR: begin
                word.jump        = 1'b1;
                word.jmp_trg_reg = 1'b1;
                word.agu_op      = AGU_REG;
            end
            K_JALR: begin
                word.jump        = 1'b1;
                word.jmp_trg_reg = 1'b1;
                word.agu_op      = AGU_REG;
                word.reg_wr_en   = 1'b1;
                word.dst         = DST_RD;
                word.wb_src      = 1'b1;
                word.src_a       = SRC_A_LINK;
                word.alu_op      = ALU_PASS;
            end
            K_BRANCH: begin
                word.branch  = 1'b1;
                word.alu_op  = ALU_CMP;
                word.src_a   = SRC_A_RS;
                word.ext     = EXT_SIGN;
                word.agu_src = 1'b1;
                word.agu_op  = AGU_PC_REL;
            end
            K_JUMP: begin
                word.jump    = 1'b1;
                word.agu_src = 1'b1;
                word.agu_op  = AGU_JUMP;
                // link_ret distinguishes JAL from J
                if (key[4]) begin
                    word.reg_wr_en = 1'b1;
                    word.dst       = DST_RA;
                    word.wb_src    = 1'b1;
                    word.src_a     = SRC_A_LINK;
                    word.alu_op    = ALU_PASS;
                end
            end
            default: illegal = 1'b1;
        endcase
        if (illegal)
            word = '0;
    end

endmodule

// File: rtl/ctrl_pipeline_unit.sv
// ID-stage control: registers the decoded control word into ID/EX, inserts bubbles,
// and drains the pipeline after HALT.
//   state     | meaning
//   ST_RUN    | normal issue, priority flush > hazard > !valid > halt > decode
//   ST_DRAIN  | HALT accepted, bubbles while older instructions retire
//   ST_HALTED | pipeline empty, held until reset
module ctrl_pipeline_unit
    import ctrl_pkg::*;
#(
    parameter int ALU_OP_W     = 4,
    parameter int AGU_OP_W     = 3,
    parameter int DRAIN_CYCLES = 4
) (
    input  logic                i_clk,
    input  logic                i_reset,
    input  logic                i_valid,
    input  logic [5:0]          i_funct,
    input  logic                i_flg_pc_modify,
    input  logic                i_flg_link_ret,
    input  logic                i_flg_inmediate,
    input  logic                i_flg_mem_op,
    input  logic                i_flg_mem_type,
    input  logic                i_flg_halt,
    input  logic [1:0]          i_flg_addr_type,
    input  logic                i_hazard_detected,
    input  logic                i_flush,
    output logic                o_valid,
    output logic [1:0]          o_flg_ALU_src_a,
    output logic [1:0]          o_flg_ALU_dst,
    output logic [1:0]          o_extend_sign,
    output logic                o_flg_ALU_src_b,
    output logic                o_flg_AGU_src_addr,
    output logic                o_flg_jump,
    output logic                o_flg_branch,
    output logic                o_flg_reg_wr_en,
    output logic                o_flg_mem_wr_en,
    output logic                o_flg_wb_src,
    output logic                o_flg_jmp_trg_reg,
    output logic [ALU_OP_W-1:0] o_ALU_opcode,
    output logic [AGU_OP_W-1:0] o_flg_AGU_opcode,
    output logic                o_stall_fetch,
    output logic                o_halted,
    output logic                o_illegal
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

    ctrl_word_t       dec_word;
    logic             dec_illegal;
    ctrl_word_t       word_q;
    logic             valid_q;
    logic             halted_q;
    logic             illegal_q;
    state_t           state;
    logic [CNT_W-1:0] drain_cnt;

    ctrl_decode u_decode (
        .key      ({i_flg_pc_modify, i_flg_link_ret, i_flg_addr_type, i_flg_inmediate, i_flg_mem_op}),
        .funct    (i_funct),
        .mem_type (i_flg_mem_type),
        .word     (dec_word),
        .illegal  (dec_illegal)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state     <= ST_RUN;
            drain_cnt <= '0;
            word_q    <= '0;
            valid_q   <= 1'b0;
            halted_q  <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            word_q  <= '0;
            valid_q <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (!i_flush && !i_hazard_detected && i_valid) begin
                        if (i_flg_halt) begin
                            state     <= ST_DRAIN;
                            drain_cnt <= CNT_W'(DRAIN_CYCLES - 1);
                        end else if (dec_illegal) begin
                            illegal_q <= 1'b1;
                        end else begin
                            word_q  <= dec_word;
                            valid_q <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state    <= ST_HALTED;
                        halted_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - 1'b1;
                    end
                end
                ST_HALTED: ;
                default: state <= ST_RUN;
            endcase
        end
    end

    assign o_stall_fetch      = (state != ST_RUN) || i_hazard_detected;
    assign o_valid            = valid_q;
    assign o_halted           = halted_q;
    assign o_illegal          = illegal_q;
    assign o_flg_ALU_src_a    = word_q.src_a;
    assign o_flg_ALU_dst      = word_q.dst;
    assign o_extend_sign      = word_q.ext;
    assign o_flg_ALU_src_b    = word_q.src_b;
    assign o_flg_AGU_src_addr = word_q.agu_src;
    assign o_flg_jump         = word_q.jump;
    assign o_flg_branch       = word_q.branch;
    assign o_flg_reg_wr_en    = word_q.reg_wr_en;
    assign o_flg_mem_wr_en    = word_q.mem_wr_en;
    assign o_flg_wb_src       = word_q.wb_src;
    assign o_flg_jmp_trg_reg  = word_q.jmp_trg_reg;
    assign o_ALU_opcode       = ALU_OP_W'(word_q.alu_op);
    assign o_flg_AGU_opcode   = AGU_OP_W'(word_q.agu_op);

endmodule

// File: tb/tb_ctrl_pipeline_unit.sv
// Randomized and directed bench for ctrl_pipeline_unit against a behavioural
// model of the class table, issue priority and HALT drain timing.
module tb_ctrl_pipeline_unit;

    localparam int DRAIN = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid;
    logic [5:0] funct;
    logic       pc_mod, link, imm, mem_op, mem_type, halt;
    logic [1:0] addr_type;
    logic       hazard, flush;

    logic       o_valid;
    logic [1:0] o_src_a, o_dst, o_ext;
    logic       o_src_b, o_agu_src, o_jump, o_branch, o_reg_wr, o_mem_wr, o_wb, o_jt;
    logic [3:0] o_alu;
    logic [2:0] o_agu;
    logic       o_stall, o_halted, o_illegal;

    ctrl_pipeline_unit #(.ALU_OP_W(4), .AGU_OP_W(3), .DRAIN_CYCLES(DRAIN)) dut (
        .i_clk              (clk),
        .i_reset            (rst),
        .i_valid            (valid),
        .i_funct            (funct),
        .i_flg_pc_modify    (pc_mod),
        .i_flg_link_ret     (link),
        .i_flg_inmediate    (imm),
        .i_flg_mem_op       (mem_op),
        .i_flg_mem_type     (mem_type),
        .i_flg_halt         (halt),
        .i_flg_addr_type    (addr_type),
        .i_hazard_detected  (hazard),
        .i_flush            (flush),
        .o_valid            (o_valid),
        .o_flg_ALU_src_a    (o_src_a),
        .o_flg_ALU_dst      (o_dst),
        .o_extend_sign      (o_ext),
        .o_flg_ALU_src_b    (o_src_b),
        .o_flg_AGU_src_addr (o_agu_src),
        .o_flg_jump         (o_jump),
        .o_flg_branch       (o_branch),
        .o_flg_reg_wr_en    (o_reg_wr),
        .o_flg_mem_wr_en    (o_mem_wr),
        .o_flg_wb_src       (o_wb),
        .o_flg_jmp_trg_reg  (o_jt),
        .o_ALU_opcode       (o_alu),
        .o_flg_AGU_opcode   (o_agu),
        .o_stall_fetch      (o_stall),
        .o_halted           (o_halted),
        .o_illegal          (o_illegal)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          halt_age = -1;
    bit          model_live = 1'b0;
    logic [21:0] exp_word = '0;
    logic        exp_halted = 1'b0;
    logic        exp_ill = 1'b0;

    logic [5:0] r_list [15] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h20, 6'h21,
                                6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2a};
    logic [5:0] i_list [7]  = '{6'h08, 6'h09, 6'h0a, 6'h0c, 6'h0d, 6'h0e, 6'h0f};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at t=%0t", tag, got, exp, $time);
    endtask

    function automatic int r_alu(input logic [5:0] f);
        case (f)
            6'h00, 6'h04: return 1;
            6'h02, 6'h06: return 0;
            6'h03, 6'h07: return 2;
            6'h20:        return 12;
            6'h21:        return 4;
            6'h22, 6'h23: return 5;
            6'h24:        return 6;
            6'h25:        return 7;
            6'h26:        return 8;
            6'h27:        return 9;
            6'h2a:        return 10;
            default:      return -1;
        endcase
    endfunction

    function automatic int i_alu(input logic [5:0] f);
        case (f)
            6'h08:   return 12;
            6'h09:   return 4;
            6'h0a:   return 10;
            6'h0c:   return 6;
            6'h0d:   return 7;
            6'h0e:   return 8;
            6'h0f:   return 3;
            default: return -1;
        endcase
    endfunction

    // Field order: src_a, dst, ext, src_b, agu_src, jump, branch, reg_wr, mem_wr, wb, jt, alu, agu
    function automatic logic [20:0] model_word(input logic [5:0] k, input logic [5:0] f,
                                               input logic mt, output bit legal);
        logic [1:0] sa, dst, ext;
        logic       sb, ags, j, b, rw, mw, wb, jt;
        int         alu;
        logic [2:0] agu;
        sa = 0; dst = 0; ext = 0; sb = 0; ags = 0; j = 0; b = 0;
        rw = 0; mw = 0; wb = 0; jt = 0; alu = 0; agu = 0;
        legal = 1'b1;
        if (!k[5] && !k[1]) begin
            alu = r_alu(f);
            legal = (alu >= 0);
            sa = (f <= 6'h03) ? 2'd2 : 2'd1;
            dst = 2'd1; rw = 1; wb = 1;
        end else if (k == 6'b000010) begin
            alu = i_alu(f);
            legal = (alu >= 0);
            sa = 2'd1; sb = 1; rw = 1; wb = 1;
            ext = (f == 6'h0c || f == 6'h0d || f == 6'h0e) ? 2'd0 : (f == 6'h0f) ? 2'd2 : 2'd1;
        end else if (k == 6'b000011) begin
            sa = 2'd1; ext = 2'd1; agu = 3'd1;
            if (mt) mw = 1; else rw = 1;
        end else if (k == 6'b100000 || k == 6'b110000) begin
            j = 1; jt = 1; agu = 3'd4;
            if (k[4]) begin rw = 1; dst = 2'd1; wb = 1; sa = 2'd3; alu = 3; end
        end else if (k == 6'b101010) begin
            b = 1; alu = 11; sa = 2'd1; ext = 2'd1; ags = 1; agu = 3'd2;
        end else if (k[5] && k[3:0] == 4'b0100) begin
            j = 1; ags = 1; agu = 3'd3;
            if (k[4]) begin rw = 1; dst = 2'd2; wb = 1; sa = 2'd3; alu = 3; end
        end else begin
            legal = 1'b0;
        end
        return {sa, dst, ext, sb, ags, j, b, rw, mw, wb, jt, alu[3:0], agu};
    endfunction

    task automatic drive(input logic v, input logic [5:0] k, input logic [5:0] f, input logic mt,
                         input logic h, input logic hz, input logic fl);
        valid = v;
        {pc_mod, link, addr_type, imm, mem_op} = k;
        funct = f; mem_type = mt; halt = h; hazard = hz; flush = fl;
    endtask

    task automatic rand_instr(input bit allow_any, output logic [5:0] k, output logic [5:0] f,
                              output logic mt);
        int sel;
        sel = int'($urandom_range(0, 7));
        mt  = 1'($urandom);
        f   = 6'($urandom);
        if (allow_any && $urandom_range(0, 9) == 0) begin
            k = 6'($urandom);
        end else begin
            case (sel)
                0:       begin k = {1'b0, 3'($urandom), 1'b0, 1'($urandom)}; f = r_list[$urandom_range(0, 14)]; end
                1:       k = 6'b100000;
                2:       k = 6'b110000;
                3:       k = 6'b000011;
                4:       begin k = 6'b000010; f = i_list[$urandom_range(0, 6)]; end
                5:       k = 6'b101010;
                default: k = {1'b1, 1'($urandom), 4'b0100};
            endcase
        end
    endtask

    task automatic step();
        logic [20:0] f;
        logic [21:0] obs;
        bit          legal;
        #1;
        if (model_live)
            chk("stall_fetch", 32'(o_stall), 32'((halt_age >= 0) ? 1'b1 : hazard));
        if (rst) begin
            exp_word = '0; exp_halted = 1'b0; exp_ill = 1'b0; halt_age = -1;
            model_live = 1'b1;
        end else if (halt_age >= 0) begin
            halt_age++;
            exp_word = '0;
            exp_halted = (halt_age >= DRAIN);
        end else begin
            exp_word = '0;
            if (!flush && !hazard && valid) begin
                if (halt) begin
                    halt_age = 0;
                end else begin
                    f = model_word({pc_mod, link, addr_type, imm, mem_op}, funct, mem_type, legal);
                    if (legal) exp_word = {1'b1, f};
                    else exp_ill = 1'b1;
                end
            end
        end
        @(posedge clk);
        #1;
        obs = {o_valid, o_src_a, o_dst, o_ext, o_src_b, o_agu_src, o_jump, o_branch,
               o_reg_wr, o_mem_wr, o_wb, o_jt, o_alu, o_agu};
        chk("ctrl_word", 32'(obs), 32'(exp_word));
        chk("halted", 32'(o_halted), 32'(exp_halted));
        chk("illegal", 32'(o_illegal), 32'(exp_ill));
        @(negedge clk);
    endtask

    localparam logic [5:0] K_R   = 6'b000000;
    localparam logic [5:0] F_ADDU = 6'b100001;

    initial begin
        logic [5:0] k, f;
        logic       mt;

        rst = 1'b1;
        drive(0, 6'd0, 6'd0, 0, 0, 0, 0);
        @(negedge clk);
        step();
        step();
        rst = 1'b0;

        drive(1, K_R, F_ADDU, 0, 0, 0, 0); step();
        chk("addu_alu", 32'(o_alu), 32'(4'b0100));
        chk("addu_src_a", 32'(o_src_a), 32'(2'b01));
        chk("addu_dst", 32'(o_dst), 32'(2'b01));
        chk("addu_wr_wb", 32'({o_valid, o_reg_wr, o_wb}), 32'(3'b111));

        drive(1, 6'b000011, 6'd5, 0, 0, 0, 0); step();
        chk("lw_wr", 32'({o_reg_wr, o_mem_wr, o_wb}), 32'(3'b100));
        drive(1, 6'b000011, 6'd5, 1, 0, 0, 0); step();
        chk("sw_wr", 32'({o_reg_wr, o_mem_wr}), 32'(2'b01));

        drive(1, K_R, F_ADDU, 0, 0, 1, 0); step(); step();
        drive(1, K_R, F_ADDU, 0, 0, 0, 0); step();

        repeat (300) begin
            rand_instr(1'b0, k, f, mt);
            drive(1'($urandom_range(0, 7) != 0), k, f, mt, 0,
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
            step();
        end

        // HALT drain with flushes and junk during DRAIN, then reset
        rst = 1'b1; step(); rst = 1'b0;
        drive(1, K_R, F_ADDU, 0, 0, 0, 0); step();
        drive(1, 6'd0, 6'd0, 0, 1, 0, 0); step();
        repeat (3) begin drive(1, K_R, F_ADDU, 0, 0, 0, 1); step(); end
        repeat (6) begin
            rand_instr(1'b0, k, f, mt);
            drive(1, k, f, mt, 1'($urandom), 1'($urandom), 1'($urandom));
            step();
        end
        chk("halted_hold", 32'(o_halted), 32'(1'b1));
        rst = 1'b1; step(); rst = 1'b0;
        chk("halted_reset", 32'(o_halted), 32'(1'b0));

        // HALT killed by flush in the same cycle
        drive(1, 6'd0, 6'd0, 0, 1, 0, 1); step();
        drive(0, 6'd0, 6'd0, 0, 0, 0, 0);
        repeat (8) step();
        drive(1, K_R, F_ADDU, 0, 0, 0, 0); step();

        // HALT together with hazard: stall first, accept on the clean cycle
        drive(1, 6'd0, 6'd0, 0, 1, 1, 0); step();
        drive(1, 6'd0, 6'd0, 0, 1, 0, 0); step();
        drive(0, 6'd0, 6'd0, 0, 0, 0, 0);
        repeat (6) step();

        // reset mid-drain
        rst = 1'b1; step(); rst = 1'b0;
        drive(1, 6'd0, 6'd0, 0, 1, 0, 0); step();
        drive(0, 6'd0, 6'd0, 0, 0, 0, 0); step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        drive(1, K_R, F_ADDU, 0, 0, 0, 0); step();

        // illegal encodings are sticky until reset
        drive(1, K_R, 6'b111111, 0, 0, 0, 0); step();
        drive(1, 6'b111111, 6'd0, 0, 0, 0, 0); step();
        drive(1, K_R, F_ADDU, 0, 0, 0, 0); step(); step();
        rst = 1'b1; step(); rst = 1'b0;
        drive(1, K_R, F_ADDU, 0, 0, 0, 0); step();

        repeat (200) begin
            rand_instr(1'b1, k, f, mt);
            drive(1'($urandom_range(0, 7) != 0), k, f, mt, 0,
                  1'($urandom_range(0, 5) == 0), 1'($urandom_range(0, 7) == 0));
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
